// File: rtl/reel_stop_sequencer.sv
// Reel-stop sequencer: releases NUM_REELS reels in index order on a tick-based
// schedule (reel i stops after FIRST_DELAY + i*STAGGER ticks). A start restarts
// the spin. done pulses on the edge where the last reel stops.
// Optional macro REEL_EARLY_STOP_EN adds a stop_btn input. Each stop_btn pulse
// stops the lowest-index reel that is still spinning, without waiting for a tick.
module reel_stop_sequencer #(
  parameter int unsigned NUM_REELS   = 4,
  parameter int unsigned FIRST_DELAY = 2,
  parameter int unsigned STAGGER     = 1,
  parameter int unsigned CNT_W       = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick,
  input  logic                 start,
`ifdef REEL_EARLY_STOP_EN
  input  logic                 stop_btn,
`endif
  output logic [NUM_REELS-1:0] stop,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [0:0] {StIdle, StSpin} state_e;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d, cnt_inc;
  logic [NUM_REELS-1:0]   stop_q, stop_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [NUM_REELS-1:0]   early_mask;

  // Lowest still-spinning reel, selected by an early-stop press.
  always_comb begin
    early_mask = '0;
`ifdef REEL_EARLY_STOP_EN
    if (stop_btn) early_mask = ~stop_q & (stop_q + 1'b1);
`endif
  end

  // Next-state and output computation; start has priority over tick and completion.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stop_d  = stop_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          stop_d  = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = StSpin;
        end
      end
      StSpin: begin
        if (start) begin
          stop_d = '0;
          cnt_d  = '0;
          busy_d = 1'b1;
        end else begin
          if (tick) begin
            cnt_d = cnt_inc;
            for (int i = 0; i < int'(NUM_REELS); i++) begin
              if (cnt_inc >= CNT_W'(FIRST_DELAY + i * STAGGER)) stop_d[i] = 1'b1;
            end
          end
          // Merging with OR means a reel hit by both tick and button stops once.
          stop_d = stop_d | early_mask;
          if (&stop_d) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and registered outputs with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      stop_q  <= '1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stop_q  <= stop_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign stop = stop_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: doc/reel_stop_sequencer.md
Name: reel_stop_sequencer

Overview:
- Parametrised reel-stop scheduler for the slot machine; generalises the fixed four-reel staggered-stop logic.
- Runs on the system clock with a slow tick enable (e.g. the 2 Hz pulse) instead of a derived clock.
- Releases N reels in order on a programmable schedule, restarts cleanly on every new spin and signals completion to the game controller.

Parameters:
- NUM_REELS, 4, number of reels / stop outputs (1..16).
- FIRST_DELAY, 2, ticks from start to reel 0 stopping (>=1).
- STAGGER, 1, extra ticks between consecutive reel stops (>=0; 0 = all stop together).
- CNT_W, 8, tick counter width; must hold FIRST_DELAY+(NUM_REELS-1)*STAGGER.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- tick  in  1  one-clk-wide enable pulse, slow timebase.
- start  in  1  one-clk pulse: begin a new spin.
- stop  out  NUM_REELS  stop[i]=1 -> reel i stationary; 0 -> spinning.
- busy  out  1  high while a spin is in progress.
- done  out  1  one-clk pulse when the last reel stops.

Behaviour:
- Reset: rst sampled on posedge clk only. stop=all ones (reels stationary), busy=0, done=0, cnt=0, state IDLE. Reset mid-spin aborts immediately with the same values.
- Threshold for reel i: T_i = FIRST_DELAY + i*STAGGER, computed at elaboration.
- FSM states: IDLE, SPIN.
- IDLE:
  - stop holds its last value; ticks are ignored.
  - start -> next edge: stop=0, cnt=0, busy=1, state SPIN.
- SPIN:
  - On tick: cnt <= cnt+1, saturating at all ones.
  - On tick: stop[i] <= 1 for every i with cnt+1 >= T_i. stop bits are sticky until the next start.
  - On the edge where stop becomes all ones: done=1 for exactly that cycle, busy=0, state IDLE.
- Latency: reel i stop rises on the clk edge that samples the T_i-th tick after start. If start and tick arrive together, that tick does not count.
- Restart: start during SPIN re-initialises the spin (stop=0, cnt=0, done=0). Start has priority over a simultaneous tick or a simultaneous completion; done is suppressed in that case.
- STAGGER=0: all reels stop on the same tick; single done pulse.
- A tick held high for multiple cycles counts once per cycle. Producing a single-cycle tick is the source's responsibility.
- No combinational path from inputs to outputs; all outputs are registered.

Optional Feature:
- Macro: REEL_EARLY_STOP_EN.
- Defined:
  - Adds input port stop_btn (1 bit, one-clk pulse).
  - stop_btn in SPIN sets the lowest-index reel whose stop bit is 0 to 1 on the next edge, without waiting for a tick.
  - Remaining reels keep their absolute thresholds.
  - If this stops the last reel, done pulses on that edge.
  - stop_btn in IDLE is ignored.
  - stop_btn together with start: start wins.
  - stop_btn together with a tick that stops the same reel: that reel stops once; no second reel is stopped.
- Undefined: port absent; stop timing purely tick-driven.

Test Plan:
- Defaults; rst 2 cycles, then start, then 5 ticks spaced 10 clks -> stop=0000 after start; 0001, 0011, 0111, 1111 on ticks 2-5; done one cycle coincident with 1111; busy 1->0 then.
- Defaults; start, 3 ticks (stop=0011), start again -> stop=0000, cnt restarts; reel 0 next stops on 2nd subsequent tick; no done from the aborted spin.
- NUM_REELS=6, FIRST_DELAY=1, STAGGER=0; start, 1 tick -> stop=111111 and done on the same edge; further ticks -> no further done.
- Defaults; start and tick on the same cycle, then 2 ticks -> stop[0] rises only on the 2nd separate tick.
- Defaults; rst asserted with stop=0011 mid-spin -> next edge stop=1111, busy=0, done=0; subsequent ticks have no effect until start.
- REEL_EARLY_STOP_EN; start, stop_btn on cycle 3, no ticks -> stop=0001 next edge; 3 further stop_btn pulses -> 1111 and done on the 4th; busy=0.
